// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit:
// opcodes, ALUOp codes, FSM states, instruction classes, trap causes.
package ctrl_pkg;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    C_R,
    C_I,
    C_BEQ,
    C_JAL,
    C_LD,
    C_ST
  } cls_t;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_FETCH   = 2'b10;
  localparam logic [1:0] CAUSE_DATA    = 2'b11;

endpackage

// File: rtl/opcode_class_decoder.sv
// Combinational opcode classifier.
// Maps the IR opcode field to an instruction class plus a legal flag.
module opcode_class_decoder
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 7
) (
  input  logic [OPCODE_W-1:0] opcode,
  output cls_t                cls,
  output logic                legal
);

  // one-hot match of the supported opcodes
  always_comb begin
    cls   = C_R;
    legal = 1'b1;
    unique case (1'b1)
      (opcode == OPCODE_W'(OP_R)):   cls = C_R;
      (opcode == OPCODE_W'(OP_I)):   cls = C_I;
      (opcode == OPCODE_W'(OP_BEQ)): cls = C_BEQ;
      (opcode == OPCODE_W'(OP_JAL)): cls = C_JAL;
      (opcode == OPCODE_W'(OP_LD)):  cls = C_LD;
      (opcode == OPCODE_W'(OP_ST)):  cls = C_ST;
      default:                       legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle FSM controller for the RISC-V datapath.
// Sequences FETCH/DECODE/EXECUTE/MEM/WB, guards memory waits, traps, counts retires.
module multicycle_control_unit
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 7,
  parameter int ALU_OP_W    = 2,
  parameter int MEM_TIMEOUT = 16,
  parameter int RETIRE_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  input  logic                stall,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                pc_write,
  output logic                alu_src,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                branch,
  output logic                jump,
  output logic                mem_2_reg,
  output logic                reg_write,
  output logic                instr_done,
  output logic                trap,
  output logic [1:0]          trap_cause,
  output logic [RETIRE_W-1:0] retired
);

  localparam int CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t state_q, state_d;
  cls_t   cls_q, cls_d;
  cls_t   dec_cls;
  logic   dec_legal;

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          cause_q, cause_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;
  logic [1:0]          alu_op_i;
  logic                hold;

  opcode_class_decoder #(
    .OPCODE_W(OPCODE_W)
  ) u_dec (
    .opcode(opcode),
    .cls   (dec_cls),
    .legal (dec_legal)
  );

  assign hold       = stall && (state_q != S_TRAP);
  assign alu_op     = ALU_OP_W'(alu_op_i);
  assign trap_cause = cause_q;
  assign retired    = retired_q;

  // next state, wait counter and decoded control outputs
  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    cnt_d      = cnt_q;
    cause_d    = cause_q;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    alu_src    = 1'b0;
    alu_op_i   = ALU_ADD;
    branch     = 1'b0;
    jump       = 1'b0;
    mem_2_reg  = 1'b0;
    reg_write  = 1'b0;
    instr_done = 1'b0;
    trap       = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_TRAP;
          cause_d = CAUSE_FETCH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DECODE: begin
        cls_d = dec_cls;
        if (dec_legal) begin
          state_d = S_EXECUTE;
        end else begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      S_EXECUTE: begin
        unique case (cls_q)
          C_R: begin
            alu_op_i = ALU_FUNCT;
            state_d  = S_WB;
          end
          C_I: begin
            alu_src  = 1'b1;
            alu_op_i = ALU_FUNCT;
            state_d  = S_WB;
          end
          C_LD, C_ST: begin
            alu_src = 1'b1;
            state_d = S_MEM;
            cnt_d   = '0;
          end
          C_BEQ: begin
            alu_op_i   = ALU_SUB;
            branch     = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
            cnt_d      = '0;
          end
          C_JAL: begin
            jump    = 1'b1;
            state_d = S_WB;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        mem_read  = (cls_q == C_LD);
        mem_write = (cls_q != C_LD);
        if (mem_ready) begin
          if (cls_q == C_LD) begin
            state_d = S_WB;
          end else begin
            instr_done = 1'b1;
            state_d    = S_FETCH;
            cnt_d      = '0;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_TRAP;
          cause_d = CAUSE_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_2_reg  = (cls_q == C_LD);
        instr_done = 1'b1;
        state_d    = S_FETCH;
        cnt_d      = '0;
      end
      S_TRAP: trap = 1'b1;
      default: state_d = S_FETCH;
    endcase
    if (hold || rst) begin
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      branch     = 1'b0;
      jump       = 1'b0;
      reg_write  = 1'b0;
      instr_done = 1'b0;
    end
    if (hold) begin
      state_d = state_q;
      cls_d   = cls_q;
      cnt_d   = cnt_q;
      cause_d = cause_q;
    end
    retired_d = retired_q + RETIRE_W'(instr_done);
  end

  // state, class, counters and trap cause registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      cls_q     <= C_R;
      cnt_q     <= '0;
      cause_q   <= CAUSE_NONE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      cnt_q     <= cnt_d;
      cause_q   <= cause_d;
      retired_q <= retired_d;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit.
// Vector table for normal flow plus sequences for timeouts, traps, reset, wrap.
module tb_multicycle_control_unit;

  localparam logic [6:0] R   = 7'b0110011;
  localparam logic [6:0] I   = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] BAD = 7'b1111111;

  // {mr,mw,irw,pcw,src,op[1:0],br,jp,m2r,rw,done}
  localparam logic [11:0] K_0    = 12'b0000_0000_0000;
  localparam logic [11:0] K_MR   = 12'b1000_0000_0000;
  localparam logic [11:0] K_FRDY = 12'b1011_0000_0000;
  localparam logic [11:0] K_EXR  = 12'b0000_0100_0000;
  localparam logic [11:0] K_EXI  = 12'b0000_1100_0000;
  localparam logic [11:0] K_EXM  = 12'b0000_1000_0000;
  localparam logic [11:0] K_EXB  = 12'b0000_0011_0001;
  localparam logic [11:0] K_EXJ  = 12'b0000_0000_1000;
  localparam logic [11:0] K_MW   = 12'b0100_0000_0000;
  localparam logic [11:0] K_MWD  = 12'b0100_0000_0001;
  localparam logic [11:0] K_WB   = 12'b0000_0000_0011;
  localparam logic [11:0] K_WBL  = 12'b0000_0000_0111;

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic        rdy;
    logic        stl;
    logic [11:0] ctl;
    logic [3:0]  ret;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic       mem_ready = 1'b0;
  logic       stall = 1'b0;
  logic       mem_read, mem_write, ir_write, pc_write;
  logic       alu_src, branch, jump, mem_2_reg;
  logic       reg_write, instr_done, trap;
  logic [1:0] alu_op, trap_cause;
  logic [3:0] retired;

  int   nchk = 0;
  int   nerr = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  multicycle_control_unit #(
    .OPCODE_W   (7),
    .ALU_OP_W   (2),
    .MEM_TIMEOUT(16),
    .RETIRE_W   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .stall     (stall),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .ir_write  (ir_write),
    .pc_write  (pc_write),
    .alu_src   (alu_src),
    .alu_op    (alu_op),
    .branch    (branch),
    .jump      (jump),
    .mem_2_reg (mem_2_reg),
    .reg_write (reg_write),
    .instr_done(instr_done),
    .trap      (trap),
    .trap_cause(trap_cause),
    .retired   (retired)
  );

  task automatic add(input logic r, input logic [6:0] o,
                     input logic rd, input logic s,
                     input logic [11:0] c, input logic [3:0] rt);
    vec_t v;
    v.rst = r;
    v.op  = o;
    v.rdy = rd;
    v.stl = s;
    v.ctl = c;
    v.ret = rt;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic r, input logic [6:0] o,
                       input logic rd, input logic s);
    rst       = r;
    opcode    = o;
    mem_ready = rd;
    stall     = s;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [11:0] c,
                     input logic t, input logic [1:0] ca,
                     input logic [3:0] rt);
    logic [18:0] act;
    logic [18:0] exp;
    @(negedge clk);
    act = {mem_read, mem_write, ir_write, pc_write, alu_src,
           alu_op, branch, jump, mem_2_reg, reg_write,
           instr_done, trap, trap_cause, retired};
    exp = {c, t, ca, rt};
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s t=%0t got %b want %b", nm, $time, act, exp);
    end
  endtask

  task automatic step(input string nm, input logic r,
                      input logic [6:0] o, input logic rd,
                      input logic s, input logic [11:0] c,
                      input logic t, input logic [1:0] ca,
                      input logic [3:0] rt);
    drive(r, o, rd, s);
    chk(nm, c, t, ca, rt);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit");
    $fatal(1);
  end

  initial begin
    // R, I, LD (3 wait), BEQ, ST (1 wait), JAL, R with WB stall
    add(1, R, 1, 0, K_MR,   0);
    add(0, R, 1, 0, K_FRDY, 0);
    add(0, R, 1, 0, K_0,    0);
    add(0, R, 1, 0, K_EXR,  0);
    add(0, R, 1, 0, K_WB,   0);
    add(0, I, 1, 0, K_FRDY, 1);
    add(0, I, 1, 0, K_0,    1);
    add(0, I, 1, 0, K_EXI,  1);
    add(0, I, 1, 0, K_WB,   1);
    add(0, LD, 1, 0, K_FRDY, 2);
    add(0, LD, 1, 0, K_0,    2);
    add(0, LD, 1, 0, K_EXM,  2);
    add(0, LD, 0, 0, K_MR,   2);
    add(0, LD, 0, 0, K_MR,   2);
    add(0, LD, 0, 0, K_MR,   2);
    add(0, LD, 1, 0, K_MR,   2);
    add(0, LD, 1, 0, K_WBL,  2);
    add(0, BQ, 1, 0, K_FRDY, 3);
    add(0, BQ, 1, 0, K_0,    3);
    add(0, BQ, 1, 0, K_EXB,  3);
    add(0, ST, 1, 0, K_FRDY, 4);
    add(0, ST, 1, 0, K_0,    4);
    add(0, ST, 1, 0, K_EXM,  4);
    add(0, ST, 0, 0, K_MW,   4);
    add(0, ST, 1, 0, K_MWD,  4);
    add(0, JL, 1, 0, K_FRDY, 5);
    add(0, JL, 1, 0, K_0,    5);
    add(0, JL, 1, 0, K_EXJ,  5);
    add(0, JL, 1, 0, K_WB,   5);
    add(0, R, 1, 0, K_FRDY, 6);
    add(0, R, 1, 0, K_0,    6);
    add(0, R, 1, 0, K_EXR,  6);
    for (int k = 0; k < 5; k++)
      add(0, R, 1, 1, K_0, 6);
    add(0, R, 1, 0, K_WB,   6);
    add(0, R, 1, 1, K_MR,   7);
    add(0, R, 0, 0, K_MR,   7);

    drive(1, R, 0, 0);
    tick();
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].op, tbl[i].rdy, tbl[i].stl);
      chk($sformatf("vec%0d", i), tbl[i].ctl, 1'b0, 2'b00, tbl[i].ret);
      tick();
    end

    // reset in the middle of a store wait
    step("rst_st_f",   0, ST, 1, 0, K_FRDY, 0, 2'b00, 7);
    step("rst_st_d",   0, ST, 1, 0, K_0,    0, 2'b00, 7);
    step("rst_st_e",   0, ST, 1, 0, K_EXM,  0, 2'b00, 7);
    step("rst_st_w",   0, ST, 0, 0, K_MW,   0, 2'b00, 7);
    step("rst_st_abt", 1, ST, 1, 0, K_MW,   0, 2'b00, 7);
    step("rst_st_new", 0, ST, 0, 0, K_MR,   0, 2'b00, 0);

    // fetch ready on the last allowed cycle wins over timeout
    drive(1, R, 0, 0);
    tick();
    for (int k = 0; k < 15; k++)
      step("fto_wait", 0, R, 0, 0, K_MR, 0, 2'b00, 0);
    step("fto_last", 0, R, 1, 0, K_FRDY, 0, 2'b00, 0);
    step("fto_dec",  0, R, 0, 0, K_0,    0, 2'b00, 0);
    step("fto_ex",   0, R, 0, 0, K_EXR,  0, 2'b00, 0);
    step("fto_wb",   0, R, 0, 0, K_WB,   0, 2'b00, 0);
    step("fto_next", 0, R, 0, 0, K_MR,   0, 2'b00, 1);

    // fetch timeout
    drive(1, R, 0, 0);
    tick();
    for (int k = 0; k < 16; k++)
      step("ft_wait", 0, R, 0, 0, K_MR, 0, 2'b00, 0);
    for (int k = 0; k < 3; k++)
      step("ft_trap", 0, R, 1, k[0], K_0, 1, 2'b10, 0);

    // data timeout on a load
    drive(1, LD, 0, 0);
    tick();
    step("dt_f", 0, LD, 1, 0, K_FRDY, 0, 2'b00, 0);
    step("dt_d", 0, LD, 0, 0, K_0,    0, 2'b00, 0);
    step("dt_e", 0, LD, 0, 0, K_EXM,  0, 2'b00, 0);
    for (int k = 0; k < 16; k++)
      step("dt_wait", 0, LD, 0, 0, K_MR, 0, 2'b00, 0);
    step("dt_trap", 0, LD, 1, 0, K_0, 1, 2'b11, 0);

    // illegal opcode, sticky trap, reset exit
    drive(1, BAD, 0, 0);
    tick();
    step("il_f", 0, BAD, 1, 0, K_FRDY, 0, 2'b00, 0);
    step("il_d", 0, BAD, 0, 0, K_0,    0, 2'b00, 0);
    for (int k = 0; k < 20; k++) begin
      logic [6:0] o;
      logic       rd;
      logic       s;
      o  = 7'($urandom_range(0, 127));
      rd = 1'($urandom_range(0, 1));
      s  = 1'($urandom_range(0, 1));
      step("il_trap", 0, o, rd, s, K_0, 1, 2'b01, 0);
    end
    step("il_rst",  1, R, 0, 0, K_0,  1, 2'b01, 0);
    step("il_exit", 0, R, 0, 0, K_MR, 0, 2'b00, 0);

    // retired counter wraps after 16 branches
    drive(1, BQ, 0, 0);
    tick();
    for (int k = 0; k < 16; k++) begin
      step("wr_f", 0, BQ, 1, 0, K_FRDY, 0, 2'b00, 4'(k));
      step("wr_d", 0, BQ, 1, 0, K_0,    0, 2'b00, 4'(k));
      step("wr_e", 0, BQ, 1, 0, K_EXB,  0, 2'b00, 4'(k));
    end
    step("wr_zero", 0, BQ, 0, 0, K_MR, 0, 2'b00, 0);

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
